// File: rtl/apx_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | apx_pkg : shared constants, mode encoding and mask helpers for the      |
// |           approximate integer multiplier family.                        |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
package apx_pkg;

    localparam int DEFAULT_WIDTH = 32;
    // Upper bound on WIDTH supported by the constant helpers below.
    localparam int MAX_WIDTH = 128;

    typedef enum logic [1:0] {
        MODE_EXACT = 2'd0,
        MODE_TRUNC = 2'd1,
        MODE_RND   = 2'd2
    } apx_mode_e;

    function automatic logic [MAX_WIDTH-1:0] mask_lsb(input int nab);
        logic [MAX_WIDTH-1:0] m;
        m = '1;
        m = m << nab;
        return m;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] rnd_const(input int nab);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        if (nab > 0) begin
            r = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (nab - 1);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/apx_mul_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | apx_mul_core : combinational WIDTH x WIDTH low-half multiplier with     |
// |                exact, truncated or rounded operand conditioning.       |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module apx_mul_core
    import apx_pkg::*;
#(
    parameter int        WIDTH = DEFAULT_WIDTH,
    parameter int        NAB   = 0,
    parameter apx_mode_e MODE  = MODE_EXACT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    localparam logic [MAX_WIDTH-1:0] c_MASK_WIDE = mask_lsb(NAB);
    localparam logic [MAX_WIDTH-1:0] c_RND_WIDE  = rnd_const(NAB);
    localparam logic [WIDTH-1:0]     c_MASK      = c_MASK_WIDE[WIDTH-1:0];
    localparam logic [WIDTH-1:0]     c_RND       = c_RND_WIDE[WIDTH-1:0];

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    // Masked LSBs become constant zero, so synthesis prunes their partial products.
    generate
        if (MODE == MODE_TRUNC && NAB > 0) begin : g_trunc
            assign w_a = a & c_MASK;
            assign w_b = b & c_MASK;
        end else if (MODE == MODE_RND && NAB > 0) begin : g_rnd
            assign w_a = (a + c_RND) & c_MASK;
            assign w_b = (b + c_RND) & c_MASK;
        end else begin : g_exact
            assign w_a = a;
            assign w_b = b;
        end
    endgenerate

    assign p = w_a * w_b;

endmodule
`default_nettype wire

// File: rtl/apx_int_mult.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | apx_int_mult : registered multiplier producing exact, truncated and     |
// |                rounded products of one operand pair, 1-cycle latency.   |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module apx_int_mult
    import apx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NAB   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] c_acc,
    output logic [WIDTH-1:0] c_trunc,
    output logic [WIDTH-1:0] c_rnd
);

    generate
        if (NAB < 0 || NAB >= WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_param
            $error("apx_int_mult: NAB must satisfy 0 <= NAB < WIDTH <= MAX_WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_trunc;
    logic [WIDTH-1:0] w_rnd;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_trunc;
    logic [WIDTH-1:0] r_rnd;

    apx_mul_core #(.WIDTH(WIDTH), .NAB(NAB), .MODE(MODE_EXACT)) u_mul_acc (
        .a (a),
        .b (b),
        .p (w_acc)
    );

    apx_mul_core #(.WIDTH(WIDTH), .NAB(NAB), .MODE(MODE_TRUNC)) u_mul_trunc (
        .a (a),
        .b (b),
        .p (w_trunc)
    );

    apx_mul_core #(.WIDTH(WIDTH), .NAB(NAB), .MODE(MODE_RND)) u_mul_rnd (
        .a (a),
        .b (b),
        .p (w_rnd)
    );

    // Products only load on valid input; otherwise they hold the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_trunc     <= '0;
            r_rnd       <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_acc   <= w_acc;
                r_trunc <= w_trunc;
                r_rnd   <= w_rnd;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign c_acc     = r_acc;
    assign c_trunc   = r_trunc;
    assign c_rnd     = r_rnd;

endmodule
`default_nettype wire

// File: tb/tb_apx_int_mult.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_apx_int_mult : directed checks of apx_int_mult at NAB = 0 and 4.     |
// | Rev 1.0                                                                |
// +------------------------------------------------------------------------+
module tb_apx_int_mult;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;

    logic        ov0, ov4;
    logic [31:0] acc0, trunc0, rnd0;
    logic [31:0] acc4, trunc4, rnd4;

    int tests_run;
    int tests_failed;

    apx_int_mult #(.WIDTH(32), .NAB(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (ov0),
        .c_acc     (acc0),
        .c_trunc   (trunc0),
        .c_rnd     (rnd0)
    );

    apx_int_mult #(.WIDTH(32), .NAB(4)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (ov4),
        .c_acc     (acc4),
        .c_trunc   (trunc4),
        .c_rnd     (rnd4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Drive one valid pair at the falling edge and sample #1 after the next rising edge.
    task automatic drive_valid(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle(input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        a        = va;
        b        = vb;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests_run++;
        if ({ov0, acc0, trunc0, rnd0} !== {1'b0, 96'd0}) begin
            tests_failed++;
            $display("FAIL reset_nab0: got ov=%b %h %h %h expected 0 0 0 0", ov0, acc0, trunc0, rnd0);
        end
        tests_run++;
        if ({ov4, acc4, trunc4, rnd4} !== {1'b0, 96'd0}) begin
            tests_failed++;
            $display("FAIL reset_nab4: got ov=%b %h %h %h expected 0 0 0 0", ov4, acc4, trunc4, rnd4);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nab0_small();
        drive_valid(32'd3, 32'd5);
        tests_run++;
        if ({ov0, acc0, trunc0, rnd0} !== {1'b1, 32'd15, 32'd15, 32'd15}) begin
            tests_failed++;
            $display("FAIL nab0_3x5: got ov=%b %0d %0d %0d expected 1 15 15 15", ov0, acc0, trunc0, rnd0);
        end
    endtask

    task automatic test_nab0_negative();
        drive_valid(32'hFFFF_FFF9, 32'd6);
        tests_run++;
        if ({ov0, acc0, trunc0, rnd0} !== {1'b1, 32'hFFFF_FFD6, 32'hFFFF_FFD6, 32'hFFFF_FFD6}) begin
            tests_failed++;
            $display("FAIL nab0_neg7x6: got ov=%b %h %h %h expected 1 ffffffd6 x3", ov0, acc0, trunc0, rnd0);
        end
    endtask

    task automatic test_nab0_overflow();
        drive_valid(32'h0001_0000, 32'h0001_0000);
        tests_run++;
        if ({ov0, acc0, trunc0, rnd0} !== {1'b1, 96'd0}) begin
            tests_failed++;
            $display("FAIL nab0_overflow: got ov=%b %h %h %h expected 1 0 0 0", ov0, acc0, trunc0, rnd0);
        end
    endtask

    task automatic test_nab4_basic();
        drive_valid(32'h0000_001C, 32'h0000_0029);
        tests_run++;
        if ({ov4, acc4, trunc4, rnd4} !== {1'b1, 32'd1148, 32'd512, 32'd1536}) begin
            tests_failed++;
            $display("FAIL nab4_1cx29: got ov=%b %0d %0d %0d expected 1 1148 512 1536", ov4, acc4, trunc4, rnd4);
        end
    endtask

    task automatic test_nab4_wrap();
        drive_valid(32'h7FFF_FFFF, 32'h0000_0010);
        tests_run++;
        if ({ov4, acc4, trunc4, rnd4} !== {1'b1, 32'hFFFF_FFF0, 32'hFFFF_FF00, 32'h0000_0000}) begin
            tests_failed++;
            $display("FAIL nab4_wrap: got ov=%b %h %h %h expected 1 fffffff0 ffffff00 00000000", ov4, acc4, trunc4, rnd4);
        end
    endtask

    // Continuous valid stream; each result is checked the cycle after its inputs.
    task automatic test_back_to_back();
        logic [31:0] ra, rb, exp_acc, exp_tr, exp_rn;
        int          errs0, errs4;
        errs0 = 0;
        errs4 = 0;
        for (int i = 0; i < 5000; i++) begin
            ra = $urandom;
            rb = $urandom;
            drive_valid(ra, rb);
            exp_acc = ra * rb;
            exp_tr  = (ra & 32'hFFFF_FFF0) * (rb & 32'hFFFF_FFF0);
            exp_rn  = ((ra + 32'd8) & 32'hFFFF_FFF0) * ((rb + 32'd8) & 32'hFFFF_FFF0);
            tests_run++;
            if ({ov0, acc0, trunc0, rnd0} !== {1'b1, exp_acc, exp_acc, exp_acc}) begin
                tests_failed++;
                errs0++;
                if (errs0 <= 5)
                    $display("FAIL b2b_nab0 a=%h b=%h: got ov=%b %h %h %h expected 1 %h x3", ra, rb, ov0, acc0, trunc0, rnd0, exp_acc);
            end
            tests_run++;
            if ({ov4, acc4, trunc4, rnd4} !== {1'b1, exp_acc, exp_tr, exp_rn}) begin
                tests_failed++;
                errs4++;
                if (errs4 <= 5)
                    $display("FAIL b2b_nab4 a=%h b=%h: got ov=%b %h %h %h expected 1 %h %h %h", ra, rb, ov4, acc4, trunc4, rnd4, exp_acc, exp_tr, exp_rn);
            end
        end
    endtask

    task automatic test_reset_hold();
        drive_valid(32'h0000_001C, 32'h0000_0029);
        drive_idle(32'hDEAD_BEEF, 32'h1234_5678);
        tests_run++;
        if ({ov4, acc4, trunc4, rnd4} !== {1'b0, 32'd1148, 32'd512, 32'd1536}) begin
            tests_failed++;
            $display("FAIL hold_nab4: got ov=%b %0d %0d %0d expected 0 1148 512 1536", ov4, acc4, trunc4, rnd4);
        end
        tests_run++;
        if ({ov0, acc0, trunc0, rnd0} !== {1'b0, 32'd1148, 32'd1148, 32'd1148}) begin
            tests_failed++;
            $display("FAIL hold_nab0: got ov=%b %0d %0d %0d expected 0 1148 x3", ov0, acc0, trunc0, rnd0);
        end
        // Reset asserted between edges must clear without a clock.
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({ov0, acc0, trunc0, rnd0, ov4, acc4, trunc4, rnd4} !== 194'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b %h %h %h / %b %h %h %h expected all 0", ov0, acc0, trunc0, rnd0, ov4, acc4, trunc4, rnd4);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if ({ov0, acc0, trunc0, rnd0, ov4, acc4, trunc4, rnd4} !== 194'd0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got %b %h %h %h / %b %h %h %h expected all 0", ov0, acc0, trunc0, rnd0, ov4, acc4, trunc4, rnd4);
        end
        drive_valid(32'd3, 32'd5);
        tests_run++;
        if ({ov4, acc4, trunc4, rnd4} !== {1'b1, 32'd15, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL post_reset_first_nab4: got ov=%b %0d %0d %0d expected 1 15 0 0", ov4, acc4, trunc4, rnd4);
        end
        tests_run++;
        if ({ov0, acc0} !== {1'b1, 32'd15}) begin
            tests_failed++;
            $display("FAIL post_reset_first_nab0: got ov=%b %0d expected 1 15", ov0, acc0);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;

        test_reset();
        test_nab0_small();
        test_nab0_negative();
        test_nab0_overflow();
        test_nab4_basic();
        test_nab4_wrap();
        test_back_to_back();
        test_reset_hold();

        @(negedge clk);
        in_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
